pwm_dac_driver: RTL
===================

Name: pwm_dac_driver

Overview:
- Downstream stage of the waveform generator: consumes its 8-bit sample stream and converts it to a single-bit PWM signal for an external RC low-pass DAC.
- Samples the input once per PWM period and double-buffers it, so a mid-period sample change never produces a partial pulse.
- Carries its own prescaled period counter and emits a per-period strobe, which the upstream counter/generator uses as its advance enable.

Parameters:
- WIDTH, 8, sample and period-counter width; PWM period is 2^WIDTH ticks.
- DIV, 1, clocks per tick (prescaler); legal range 1..65535.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run enable; low freezes the block.
- din  input  WIDTH  sample from the wave generator (its out bus).
- pwm  output  1  registered PWM output.
- period_done  output  1  one-clock strobe at the end of each PWM period.
- duty  output  WIDTH  currently active (latched) duty value, for debug/verification.

Behaviour:
- Reset (async, active-high):
  - pre_cnt = 0, pwm_cnt = 0, duty = 0, pwm = 0, period_done = 0.
  - Reset mid-period aborts the period immediately with no strobe.
- Prescaler:
  - pre_cnt counts 0..DIV-1 while en = 1, then wraps to 0.
  - tick = en && (pre_cnt == DIV-1). With DIV = 1, tick is high on every enabled clock.
- Period counter:
  - On tick, pwm_cnt increments modulo 2^WIDTH.
  - At wrap (pwm_cnt == 2^WIDTH-1 && tick), on the same edge: pwm_cnt <= 0, duty <= din, period_done <= 1.
  - period_done is 0 on every other clock; it is registered and high for exactly one clk.
- Duty handling:
  - The first period after reset uses duty = 0, so pwm stays low for that period.
  - din is sampled only at wrap. din changes at any other time have no effect.
- Output:
  - Every clock: pwm <= en && (pwm_cnt < duty), evaluated on the pre-edge register values.
  - pwm therefore lags pwm_cnt by one clock.
  - duty = 0 gives constant low. duty = 2^WIDTH-1 gives high for 255 of 256 ticks. 100% duty is not reachable.
- en low:
  - pre_cnt, pwm_cnt and duty hold.
  - pwm is forced to 0 on the next clock; period_done stays 0.
  - When en returns high, counting resumes from the held counts with no restart.
- Simultaneous events:
  - A wrap while din changes on the same edge latches the pre-edge din value.
  - rst overrides en and everything else.
- No arithmetic overflow beyond the defined modulo wrap. Comparison is unsigned.

Optional Feature:
- Macro: PWM_CENTER_ALIGNED_EN.
- With it defined:
  - pwm_cnt counts up 0..2^WIDTH-1, then down to 1, then back to 0 (period of 2*(2^WIDTH-1) ticks), tracked by an internal direction bit reset to up.
  - Wrap (duty load, period_done) occurs on the tick where pwm_cnt goes from 1 to 0 while counting down.
  - The pwm compare rule is unchanged, which gives a pulse symmetric about pwm_cnt = 0.
- Without it: edge-aligned sawtooth counting exactly as in Behaviour, and no direction bit is synthesized.

Test Plan:
- Reset check: assert rst at t = 3 ns, release at 8 ns (DIV = 1, din = 8'h80) -> all outputs 0 during reset.
  - First period_done 256 clocks after release; duty becomes 8'h80.
  - The next period has pwm high for exactly 128 consecutive clocks, then low for 128.
- Duty extremes: din = 0 -> pwm low for a whole period. din = 8'hFF -> pwm high 255 clocks, low 1 clock per period.
- Mid-period din change: din toggles 8'h40/8'hC0 every 7 clocks -> duty changes only on period_done edges; high time equals the din value sampled at wrap.
- Prescaler, DIV = 4: period_done spacing is 1024 clocks. With din = 8'h10, pwm is high for 64 clocks per period.
- en low for 100 clocks mid-period -> pwm is 0, counters frozen, no period_done. After re-enable, the remaining high/low time completes; the period length excluding the pause is 256 ticks.
- PWM_CENTER_ALIGNED_EN, DIV = 1, din = 8'h20 -> period_done spacing is 510 clocks; pwm is high for 63 clocks, centred on pwm_cnt = 0 across the wrap.

Source files
------------

// File: rtl/pwm_dac_driver.sv
// PWM DAC driver: latches one sample per PWM period and emits a registered pulse plus a period strobe.
// Define PWM_CENTER_ALIGNED_EN for up/down (center-aligned) counting; the default is an edge-aligned sawtooth.
module pwm_dac_driver #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic             pwm,
    output logic             period_done,
    output logic [WIDTH-1:0] duty
);
    localparam int               PRE_W    = 16;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;
    logic             done_q, done_d;
    logic             tick;
    logic             wrap;

    assign tick = en && (pre_cnt_q == PRE_LAST);

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (en) begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_ONE;
        end
    end

`ifdef PWM_CENTER_ALIGNED_EN
    logic dir_down_q, dir_down_d;

    // Triangle count: up to CNT_MAX, back down to 1; the 1->0 step closes the period.
    always_comb begin
        pwm_cnt_d  = pwm_cnt_q;
        dir_down_d = dir_down_q;
        wrap       = 1'b0;
        if (tick) begin
            if (!dir_down_q) begin
                if (pwm_cnt_q == CNT_MAX) begin
                    pwm_cnt_d  = pwm_cnt_q - CNT_ONE;
                    dir_down_d = 1'b1;
                end else begin
                    pwm_cnt_d = pwm_cnt_q + CNT_ONE;
                end
            end else begin
                pwm_cnt_d = pwm_cnt_q - CNT_ONE;
                if (pwm_cnt_q == CNT_ONE) begin
                    dir_down_d = 1'b0;
                    wrap       = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_down_q <= 1'b0;
        end else begin
            dir_down_q <= dir_down_d;
        end
    end
`else
    always_comb begin
        pwm_cnt_d = pwm_cnt_q;
        wrap      = tick && (pwm_cnt_q == CNT_MAX);
        if (tick) begin
            pwm_cnt_d = pwm_cnt_q + CNT_ONE;
        end
    end
`endif

    // Sample is taken only at wrap so a mid-period din change cannot produce a partial pulse.
    always_comb begin
        duty_d = wrap ? din : duty_q;
        done_d = wrap;
        pwm_d  = en && (pwm_cnt_q < duty_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q <= '0;
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            pwm_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            pwm_q     <= pwm_d;
            done_q    <= done_d;
        end
    end

    assign pwm         = pwm_q;
    assign period_done = done_q;
    assign duty        = duty_q;

endmodule
